// File: rtl/vga_pixel_out_if.sv
// vga_pixel_out_if: shader-facing pixel coordinate/RGB handshake plus VGA pin bundle
interface vga_pixel_out_if;
  logic [3:0] red_in;
  logic [3:0] green_in;
  logic [3:0] blue_in;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       pix_tick;
  logic       frame_start;
  logic [3:0] vga_r;
  logic [3:0] vga_g;
  logic [3:0] vga_b;
  logic       vga_hs;
  logic       vga_vs;
  logic       vga_de;
  modport master (
    input  red_in, green_in, blue_in,
    output pix_x, pix_y, pix_tick, frame_start,
    output vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de
  );
  modport slave (
    output red_in, green_in, blue_in,
    input  pix_x, pix_y, pix_tick, frame_start,
    input  vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de
  );
endinterface

// File: rtl/vga_pixel_out.sv
// vga_pixel_out: VGA timing generator publishing pixel coordinates and driving registered, blanked RGB/sync pins
module vga_pixel_out #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input logic clk,
  input logic rst_n,
  vga_pixel_out_if.master bus
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  logic [DW-1:0] div;
  logic [9:0] h, v;
  logic tick, active, hs_on, vs_on;
  assign tick   = div == DIV_LAST;
  assign active = h < H_ACT && v < V_ACT;
  assign hs_on  = h >= HS_BEG && h < HS_END;
  assign vs_on  = v >= VS_BEG && v < VS_END;
  assign bus.pix_x       = h;
  assign bus.pix_y       = v;
  assign bus.pix_tick    = tick;
  assign bus.frame_start = tick && h == '0 && v == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      div <= '0;
      h   <= '0;
      v   <= '0;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      if (tick) begin
        h <= h == H_LAST ? '0 : h + 10'd1;
        if (h == H_LAST) v <= v == V_LAST ? '0 : v + 10'd1;
      end
    end
  // Pins sample pre-tick h/v so sync, de and rgb stay aligned one tick behind pix_x/pix_y
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.vga_r  <= '0;
      bus.vga_g  <= '0;
      bus.vga_b  <= '0;
      bus.vga_de <= 1'b0;
      bus.vga_hs <= ~SYNC_POL;
      bus.vga_vs <= ~SYNC_POL;
    end else if (tick) begin
      bus.vga_r  <= active ? bus.red_in   : '0;
      bus.vga_g  <= active ? bus.green_in : '0;
      bus.vga_b  <= active ? bus.blue_in  : '0;
      bus.vga_de <= active;
      bus.vga_hs <= hs_on ? SYNC_POL : ~SYNC_POL;
      bus.vga_vs <= vs_on ? SYNC_POL : ~SYNC_POL;
    end
endmodule
